phase_shifter_tx: RTL and testbench



---
 rtl/phase_shifter_tx_pkg.sv | 13 +
 rtl/phase_shifter_tx_phsel_sync.sv | 52 +++++
 rtl/phase_shifter_tx.sv | 120 ++++++++++++
 tb/tb_phase_shifter_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/phase_shifter_tx_pkg.sv
// Shared definitions for the transmit phase shifter: tick geometry and slew FSM encoding.
package phase_shifter_tx_pkg;

    localparam int TICKS_PER_BIT = 8;
    localparam int PHASE_W       = 4;
    localparam int STEP_CNT_W    = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SLEW = 1'b1
    } slew_state_e;

endpackage

// File: rtl/phase_shifter_tx_phsel_sync.sv
// Brings the CLK80-domain phase request into CLK400 and only offers it as a new
// target once it has been seen unchanged for STABLE_CNT consecutive samples.
module phsel_sync
    import phase_shifter_tx_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic               CLK400,
    input  logic               reset,
    input  logic [PHASE_W-1:0] phsel_i,
    input  logic [PHASE_W-1:0] target_i,
    output logic [PHASE_W-1:0] target_o,
    output logic               target_load_o
);

    localparam int               CNT_W   = $clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic [PHASE_W-1:0] meta_q;
    logic [PHASE_W-1:0] sync_q;
    logic [PHASE_W-1:0] prev_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    always_ff @(posedge CLK400 or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            meta_q <= phsel_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            cnt_q  <= cnt_d;
        end
    end

    // Any bit disagreeing between samples (glitch or skewed edges) restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (sync_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign target_o      = prev_q;
    assign target_load_o = (cnt_q == CNT_MAX) && (prev_q != target_i);

endmodule

// File: rtl/phase_shifter_tx.sv
// Expands one bit per CLK400 into an 8-tick word and delays it by 0..15 ticks,
// slewing the applied delay one tick at a time toward the filtered request.
module phase_shifter_tx
    import phase_shifter_tx_pkg::*;
#(
    parameter int STEP_DIV   = 8,
    parameter int STABLE_CNT = 4
) (
    input  logic                     CLK400,
    input  logic                     reset,
    input  logic [PHASE_W-1:0]       phsel,
    input  logic                     phen,
    input  logic                     din,
    output logic [TICKS_PER_BIT-1:0] dout,
    output logic [PHASE_W-1:0]       phase_cur,
    output logic                     busy
);

    localparam logic [STEP_CNT_W-1:0] STEP_RELOAD = STEP_CNT_W'(STEP_DIV - 1);

    logic [2:0]               hist_q;
    logic [TICKS_PER_BIT-1:0] dout_q;
    logic [TICKS_PER_BIT-1:0] dout_d;
    logic [PHASE_W-1:0]       phase_q;
    logic [PHASE_W-1:0]       phase_d;
    logic [PHASE_W-1:0]       target_q;
    logic [PHASE_W-1:0]       target_d;
    logic [STEP_CNT_W-1:0]    step_q;
    logic [STEP_CNT_W-1:0]    step_d;
    logic                     busy_q;
    logic                     busy_d;
    slew_state_e              state_q;
    slew_state_e              state_d;

    logic [PHASE_W-1:0]       sync_target;
    logic                     target_load;

    phsel_sync #(
        .STABLE_CNT (STABLE_CNT)
    ) u_phsel_sync (
        .CLK400        (CLK400),
        .reset         (reset),
        .phsel_i       (phsel),
        .target_i      (target_q),
        .target_o      (sync_target),
        .target_load_o (target_load)
    );

    always_ff @(posedge CLK400 or posedge reset) begin
        if (reset) begin
            hist_q   <= '0;
            dout_q   <= '0;
            phase_q  <= '0;
            target_q <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
        end else begin
            hist_q   <= {hist_q[1:0], din};
            dout_q   <= dout_d;
            phase_q  <= phase_d;
            target_q <= target_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            state_q  <= state_d;
        end
    end

    // Tick k of the outgoing word looks back D ticks, landing in one of the last three bits.
    always_comb begin
        dout_d = '0;
        for (int k = 0; k < TICKS_PER_BIT; k++) begin
            if (k >= int'(phase_q)) begin
                dout_d[k] = hist_q[0];
            end else if (k + TICKS_PER_BIT >= int'(phase_q)) begin
                dout_d[k] = hist_q[1];
            end else begin
                dout_d[k] = hist_q[2];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        phase_d  = phase_q;
        target_d = target_load ? sync_target : target_q;
        case (state_q)
            IDLE: begin
                if (phen && (target_q != phase_q)) begin
                    step_d  = STEP_RELOAD;
                    state_d = SLEW;
                end
            end
            SLEW: begin
                if (target_q == phase_q) begin
                    state_d = IDLE;
                end else if (phen) begin
                    if (step_q == '0) begin
                        phase_d = (target_q > phase_q) ? phase_q + 1'b1 : phase_q - 1'b1;
                        if (phase_d == target_q) begin
                            state_d = IDLE;
                        end else begin
                            step_d = STEP_RELOAD;
                        end
                    end else begin
                        step_d = step_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (target_d != phase_d);
    end

    assign dout      = dout_q;
    assign phase_cur = phase_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_phase_shifter_tx.sv
// Scoreboard bench for phase_shifter_tx: stimulus queues expected values keyed by
// cycle, a monitor compares them and checks every phase_cur change against a step list.
module tb_phase_shifter_tx;

    localparam int SIG_DOUT  = 0;
    localparam int SIG_PHASE = 1;
    localparam int SIG_BUSY  = 2;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } chk_t;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic       CLK400;
    logic       reset;
    logic [3:0] phsel;
    logic       phen;
    logic       din;
    logic [7:0] dout;
    logic [3:0] phase_cur;
    logic       busy;

    chk_t chkQ[$];
    ev_t  evQ[$];
    int   cyc      = 0;
    int   nVec     = 0;
    int   nMis     = 0;
    bit   done     = 1'b0;
    logic [3:0] lastPhase = 4'd0;

    phase_shifter_tx #(
        .STEP_DIV   (8),
        .STABLE_CNT (4)
    ) dut (
        .CLK400    (CLK400),
        .reset     (reset),
        .phsel     (phsel),
        .phen      (phen),
        .din       (din),
        .dout      (dout),
        .phase_cur (phase_cur),
        .busy      (busy)
    );

    initial CLK400 = 1'b0;
    always #5 CLK400 = ~CLK400;

    always @(posedge CLK400) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK400);
        #2;
    endtask

    task automatic pushChk(input int c, input int s, input int v);
        chkQ.push_back('{c, s, v});
    endtask

    task automatic pushSteps(input int fromP, input int toP, input int firstCyc);
        int dir;
        int n;
        dir = (toP > fromP) ? 1 : -1;
        n   = dir * (toP - fromP);
        for (int k = 1; k <= n; k++) begin
            evQ.push_back('{firstCyc + 8 * (k - 1), fromP + dir * k});
        end
    endtask

    // One-cycle din pulse; w1..w4 are the words expected after the 1st..4th following edges.
    task automatic applyPulse(input logic [7:0] w1, input logic [7:0] w2,
                              input logic [7:0] w3, input logic [7:0] w4);
        int c;
        c = cyc;
        pushChk(c + 1, SIG_DOUT, int'(w1));
        pushChk(c + 2, SIG_DOUT, int'(w2));
        pushChk(c + 3, SIG_DOUT, int'(w3));
        pushChk(c + 4, SIG_DOUT, int'(w4));
        din = 1'b1;
        tick(1);
        din = 1'b0;
        tick(5);
    endtask

    task automatic applyStimulus();
        int c;
        int r;

        reset = 1'b1;
        din   = 1'b0;
        phsel = 4'd0;
        phen  = 1'b1;
        tick(1);
        pushChk(2, SIG_DOUT, 0);
        pushChk(2, SIG_PHASE, 0);
        pushChk(2, SIG_BUSY, 0);
        tick(2);
        reset = 1'b0;
        tick(4);

        applyPulse(8'h00, 8'hFF, 8'h00, 8'h00);

        c = cyc;
        phsel = 4'd15;
        pushChk(c + 6, SIG_BUSY, 0);
        pushChk(c + 7, SIG_BUSY, 1);
        pushSteps(0, 15, c + 16);
        pushChk(c + 127, SIG_BUSY, 1);
        pushChk(c + 128, SIG_BUSY, 0);
        pushChk(c + 128, SIG_PHASE, 15);
        tick(135);

        applyPulse(8'h00, 8'h00, 8'h80, 8'h7F);

        c = cyc;
        phsel = 4'd5;
        pushSteps(15, 5, c + 16);
        pushChk(c + 88, SIG_PHASE, 5);
        pushChk(c + 88, SIG_BUSY, 0);
        tick(95);

        applyPulse(8'h00, 8'hE0, 8'h1F, 8'h00);

        c = cyc;
        phsel = 4'd15;
        evQ.push_back('{c + 16, 6});
        pushSteps(6, 3, c + 24);
        pushChk(c + 39, SIG_BUSY, 1);
        pushChk(c + 40, SIG_BUSY, 0);
        tick(16);
        phsel = 4'd3;
        tick(29);
        phsel = 4'd9;
        tick(2);
        phsel = 4'd3;
        pushChk(cyc + 25, SIG_PHASE, 3);
        pushChk(cyc + 25, SIG_BUSY, 0);
        tick(30);

        c = cyc;
        phsel = 4'd12;
        pushSteps(3, 7, c + 16);
        evQ.push_back('{c + 42, 0});
        pushChk(c + 42, SIG_DOUT, 0);
        pushChk(c + 42, SIG_BUSY, 0);
        tick(42);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        r = cyc;
        pushSteps(0, 2, r + 16);
        pushChk(r + 40, SIG_PHASE, 2);
        pushChk(r + 40, SIG_BUSY, 1);
        pushSteps(2, 12, r + 52);
        pushChk(r + 123, SIG_BUSY, 1);
        pushChk(r + 124, SIG_BUSY, 0);
        pushChk(r + 124, SIG_PHASE, 12);
        tick(26);
        phen = 1'b0;
        tick(20);
        phen = 1'b1;
        tick(130);
    endtask

    function automatic string sigName(input int s);
        case (s)
            SIG_DOUT:  return "dout";
            SIG_PHASE: return "phase_cur";
            default:   return "busy";
        endcase
    endfunction

    task automatic checkOutput();
        chk_t ce;
        ev_t  ev;
        int   actual;
        while (chkQ.size() > 0 && chkQ[0].cyc <= cyc) begin
            ce = chkQ.pop_front();
            case (ce.sig)
                SIG_DOUT:  actual = int'(dout);
                SIG_PHASE: actual = int'(phase_cur);
                default:   actual = int'(busy);
            endcase
            nVec++;
            if (ce.cyc != cyc || actual != ce.val) begin
                nMis++;
                $display("[TB] FAIL %s at cyc %0d: got %0d, expected %0d (due cyc %0d)",
                         sigName(ce.sig), cyc, actual, ce.val, ce.cyc);
            end
        end
        if (phase_cur !== lastPhase) begin
            nVec++;
            if (evQ.size() == 0) begin
                nMis++;
                $display("[TB] FAIL phase_step at cyc %0d: got %0d, expected no change from %0d",
                         cyc, phase_cur, lastPhase);
            end else begin
                ev = evQ.pop_front();
                if (int'(phase_cur) != ev.val || cyc != ev.cyc) begin
                    nMis++;
                    $display("[TB] FAIL phase_step at cyc %0d: got %0d, expected %0d at cyc %0d",
                             cyc, phase_cur, ev.val, ev.cyc);
                end
            end
            lastPhase = phase_cur;
        end
    endtask

    always @(negedge CLK400) begin
        checkOutput();
        if (done) begin
            while (chkQ.size() > 0) begin
                nMis++;
                $display("[TB] FAIL %s never checked: due cyc %0d, expected %0d",
                         sigName(chkQ[0].sig), chkQ[0].cyc, chkQ[0].val);
                void'(chkQ.pop_front());
            end
            while (evQ.size() > 0) begin
                nMis++;
                $display("[TB] FAIL phase_step missing: expected %0d at cyc %0d, got %0d",
                         evQ[0].val, evQ[0].cyc, phase_cur);
                void'(evQ.pop_front());
            end
            $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
            $finish;
        end
    end

    initial begin
        applyStimulus();
        done = 1'b1;
    end

endmodule
